ysyx_22040729_hs_mem: RTL and testbench
=======================================

Name: ysyx_22040729_hs_mem

Overview:
- Byte-addressed, little-endian unified memory with one data port (R/W, byte strobes) and one instruction port (read-only).
- Each port has a valid/ready request channel, a valid/ready response channel and a programmable fixed latency, so the core can be exercised against slow memory before the AXI bridge exists.
- Out-of-range accesses are flagged with an error response and never corrupt storage.

Parameters:
- DEPTH, 65536: storage size in bytes; power of two, ≥16.
- DATA_WIDTH, 64: data-port width in bits; multiple of 8.
- INST_WIDTH, 32: instruction-port width in bits; multiple of 8.
- LATENCY, 1: cycles from request acceptance to response valid; ≥1.
- AW, $clog2(DEPTH): byte-address width (derived, not overridden).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- d_req_valid  in  1  data request valid.
- d_req_ready  out  1  data port can accept.
- d_req_addr  in  AW  byte address of lane 0.
- d_req_wen  in  1  1=write, 0=read.
- d_req_wstrb  in  DATA_WIDTH/8  byte enables; lane i → byte addr+i.
- d_req_wdata  in  DATA_WIDTH  write data, lane i = bits 8i+7:8i.
- d_rsp_valid  out  1  data response valid.
- d_rsp_ready  in  1  consumer accepts response.
- d_rsp_rdata  out  DATA_WIDTH  read data; 0 for writes/errors.
- d_rsp_err  out  1  access exceeded DEPTH.
- i_req_valid  in  1  fetch request valid.
- i_req_ready  out  1  fetch port can accept.
- i_req_addr  in  AW  fetch byte address.
- i_rsp_valid  out  1  fetch response valid.
- i_rsp_ready  in  1  consumer accepts fetch.
- i_rsp_rdata  out  INST_WIDTH  instruction bits; 0 on error.
- i_rsp_err  out  1  fetch exceeded DEPTH.

Behaviour:
- Reset: async assert forces both port FSMs to IDLE. While rst=1: *_req_ready=0, *_rsp_valid=0, *_rsp_rdata=0, *_rsp_err=0, latency counters=0. Storage is not cleared.
- Per-port FSM, two independent copies: IDLE → WAIT → RESP → IDLE.
- IDLE: req_ready=1. The accept edge is when req_valid&req_ready. It captures the result (read data or error) into the response register.
  - LATENCY=1: next state RESP.
  - LATENCY>1: next state WAIT with counter=LATENCY-1.
- WAIT: req_ready=0; counter decrements each cycle; at counter==1 go to RESP.
- RESP: rsp_valid=1; rdata/err are stable until the handshake. On rsp_valid&rsp_ready go to IDLE. No back-to-back acceptance in the same cycle, so max throughput is one transaction per LATENCY+1 cycles.
- Total latency: rsp_valid rises exactly LATENCY cycles after the accept edge.
- Range check: a data access spans addr..addr+DATA_WIDTH/8-1; a fetch spans addr..addr+INST_WIDTH/8-1. Any byte ≥DEPTH gives err=1 and rdata=0, and no byte is written.
  - The check is computed at AW+1 bits; there is no wrap-around.
  - No alignment requirement.
- Write: committed at the accept edge, only to lanes with wstrb[i]=1. wstrb=0 is a legal no-op write with err=0. Write responses have rdata=0.
- Read: byte i of rdata = mem[addr+i], sampled at the accept edge.
- Same-edge collision (data write and fetch accepted on one edge, overlapping bytes): the fetch returns the pre-write (old) bytes. The write takes effect from the next edge.
- Data read and data write never coincide (single port).
- Reset mid-transaction: in-flight responses are discarded and never presented. A write already accepted before reset remains in storage.
- Request inputs are ignored outside IDLE. The source must hold req_valid and payload until ready.

Test Plan:
- LATENCY=1: write addr 0x10, wdata 0x1122334455667788, wstrb 0xFF; then read 0x10 → d_rsp_valid one cycle after accept, rdata 0x1122334455667788, err=0.
- Strobe merge: over the above, write 0xAAAA... with wstrb 0x0F, read 0x10 → 0x11223344AAAAAAAA; fetch 0x12 → i_rsp_rdata 0x3344AAAA.
- LATENCY=3 with d_rsp_ready held low 5 cycles: rsp_valid rises 3 cycles after accept; rdata/err stay stable; req_ready=0 until the response handshake.
- Range: DEPTH=65536, data read at 0xFFFC → err=1, rdata=0; write at 0xFFF9 → err=1 and bytes 0xFFF9–0xFFFF unchanged; fetch at 0xFFFC → err=0.
- Collision: mem[0x20..0x23]=0xDEADBEEF; same-edge write 0x0 to 0x20 and fetch 0x20 → fetch 0xDEADBEEF; next fetch → 0x00000000.
- Reset during WAIT (LATENCY=4, read pending): pulse rst asynchronously mid-cycle → outputs immediately 0, no response after release; a prior write is still readable.

Source files
------------

// File: rtl/ysyx_22040729_hs_mem.sv
// ysyx_22040729_hs_mem: byte-addressed little-endian unified memory for
// bring-up of the core. One read/write data port with byte strobes and one
// read-only instruction port. Each port runs its own IDLE -> WAIT -> RESP
// controller, so responses arrive a fixed LATENCY cycles after acceptance.
//
// Handshake rules (both channels of both ports):
//   A request transfers on the rising edge where req_valid && req_ready.
//   A response transfers on the rising edge where rsp_valid && rsp_ready.
//   The source holds valid and payload until the transfer edge. The memory
//   raises req_ready only in IDLE and never during reset. It holds rsp_valid
//   and the response payload stable until the response transfer.
//
// Accesses touching any byte at or above DEPTH return err=1 and rdata=0.
// Such accesses never write storage. Read data and errors are captured at
// the accept edge. A fetch accepted on the same edge as an overlapping data
// write therefore sees the bytes as they were before that write.
module ysyx_22040729_hs_mem #(
   parameter int DEPTH      = 65536,
   parameter int DATA_WIDTH = 64,
   parameter int INST_WIDTH = 32,
   parameter int LATENCY    = 1,
   localparam int AW        = $clog2(DEPTH)
) (
   input  logic                    clk,
   input  logic                    rst,
   // data port request
   input  logic                    d_req_valid,
   output logic                    d_req_ready,
   input  logic [AW-1:0]           d_req_addr,
   input  logic                    d_req_wen,
   input  logic [DATA_WIDTH/8-1:0] d_req_wstrb,
   input  logic [DATA_WIDTH-1:0]   d_req_wdata,
   // data port response
   output logic                    d_rsp_valid,
   input  logic                    d_rsp_ready,
   output logic [DATA_WIDTH-1:0]   d_rsp_rdata,
   output logic                    d_rsp_err,
   // instruction port request
   input  logic                    i_req_valid,
   output logic                    i_req_ready,
   input  logic [AW-1:0]           i_req_addr,
   // instruction port response
   output logic                    i_rsp_valid,
   input  logic                    i_rsp_ready,
   output logic [INST_WIDTH-1:0]   i_rsp_rdata,
   output logic                    i_rsp_err
);

   localparam int DB = DATA_WIDTH / 8;
   localparam int IB = INST_WIDTH / 8;
   // Counter only has to hold LATENCY-1.
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // Storage has no reset: contents survive a reset pulse.
   logic [7:0] r_mem [DEPTH];

   // ------------------------------------------------------------------
   // Data port signals
   // ------------------------------------------------------------------
   state_t                r_d_state;
   state_t                w_d_state_nxt;
   logic [CW-1:0]         r_d_cnt;
   logic [CW-1:0]         w_d_cnt_nxt;
   logic                  w_d_req_ready;
   logic                  w_d_rsp_valid;
   logic                  w_d_accept;
   logic [AW:0]           w_d_last;
   logic                  w_d_err;
   logic [DATA_WIDTH-1:0] w_d_rdata;
   logic [DATA_WIDTH-1:0] r_d_rdata;
   logic                  r_d_err;

   // ------------------------------------------------------------------
   // Instruction port signals
   // ------------------------------------------------------------------
   state_t                r_i_state;
   state_t                w_i_state_nxt;
   logic [CW-1:0]         r_i_cnt;
   logic [CW-1:0]         w_i_cnt_nxt;
   logic                  w_i_req_ready;
   logic                  w_i_rsp_valid;
   logic                  w_i_accept;
   logic [AW:0]           w_i_last;
   logic                  w_i_err;
   logic [INST_WIDTH-1:0] w_i_rdata;
   logic [INST_WIDTH-1:0] r_i_rdata;
   logic                  r_i_err;

   // Address of the last byte touched, one bit wider than the address so an
   // access running off the top cannot wrap back to low memory.
   assign w_d_last = {1'b0, d_req_addr} + (AW+1)'(DB - 1);
   assign w_i_last = {1'b0, i_req_addr} + (AW+1)'(IB - 1);
   assign w_d_err  = (w_d_last > (AW+1)'(DEPTH - 1));
   assign w_i_err  = (w_i_last > (AW+1)'(DEPTH - 1));

   assign w_d_accept = d_req_valid & w_d_req_ready;
   assign w_i_accept = i_req_valid & w_i_req_ready;

   assign d_req_ready = w_d_req_ready;
   assign d_rsp_valid = w_d_rsp_valid;
   assign d_rsp_rdata = r_d_rdata;
   assign d_rsp_err   = r_d_err;
   assign i_req_ready = w_i_req_ready;
   assign i_rsp_valid = w_i_rsp_valid;
   assign i_rsp_rdata = r_i_rdata;
   assign i_rsp_err   = r_i_err;

   // Gather the data-port read lanes; lane i comes from addr+i.
   always_comb begin
      w_d_rdata = '0;
      for (int i = 0; i < DB; i++) begin
         w_d_rdata[8*i +: 8] = r_mem[d_req_addr + AW'(i)];
      end
   end

   // Gather the fetch lanes; lane i comes from addr+i.
   always_comb begin
      w_i_rdata = '0;
      for (int i = 0; i < IB; i++) begin
         w_i_rdata[8*i +: 8] = r_mem[i_req_addr + AW'(i)];
      end
   end

   // Commit strobed write lanes at the accept edge; errored writes are dropped.
   always_ff @(posedge clk) begin
      if (w_d_accept && d_req_wen && !w_d_err) begin
         for (int i = 0; i < DB; i++) begin
            if (d_req_wstrb[i]) begin
               r_mem[d_req_addr + AW'(i)] <= d_req_wdata[8*i +: 8];
            end
         end
      end
   end

   // Data port controller state and latency counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_d_state <= ST_IDLE;
         r_d_cnt   <= '0;
      end else begin
         r_d_state <= w_d_state_nxt;
         r_d_cnt   <= w_d_cnt_nxt;
      end
   end

   // Data port next state and handshake outputs.
   always_comb begin
      w_d_state_nxt = r_d_state;
      w_d_cnt_nxt   = r_d_cnt;
      w_d_req_ready = 1'b0;
      w_d_rsp_valid = 1'b0;
      unique case (r_d_state)
         ST_IDLE: begin
            w_d_req_ready = ~rst;
            if (d_req_valid && !rst) begin
               if (LATENCY == 1) begin
                  w_d_state_nxt = ST_RESP;
               end else begin
                  w_d_state_nxt = ST_WAIT;
                  w_d_cnt_nxt   = CW'(LATENCY - 1);
               end
            end
         end
         ST_WAIT: begin
            w_d_cnt_nxt = r_d_cnt - 1'b1;
            if (r_d_cnt == CW'(1)) begin
               w_d_state_nxt = ST_RESP;
            end
         end
         ST_RESP: begin
            w_d_rsp_valid = 1'b1;
            if (d_rsp_ready) begin
               w_d_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_d_state_nxt = ST_IDLE;
            w_d_cnt_nxt   = '0;
         end
      endcase
   end

   // Data response register: loaded once at acceptance, held until consumed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_d_rdata <= '0;
         r_d_err   <= 1'b0;
      end else if (w_d_accept) begin
         r_d_err   <= w_d_err;
         r_d_rdata <= (w_d_err || d_req_wen) ? '0 : w_d_rdata;
      end
   end

   // Instruction port controller state and latency counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_i_state <= ST_IDLE;
         r_i_cnt   <= '0;
      end else begin
         r_i_state <= w_i_state_nxt;
         r_i_cnt   <= w_i_cnt_nxt;
      end
   end

   // Instruction port next state and handshake outputs.
   always_comb begin
      w_i_state_nxt = r_i_state;
      w_i_cnt_nxt   = r_i_cnt;
      w_i_req_ready = 1'b0;
      w_i_rsp_valid = 1'b0;
      unique case (r_i_state)
         ST_IDLE: begin
            w_i_req_ready = ~rst;
            if (i_req_valid && !rst) begin
               if (LATENCY == 1) begin
                  w_i_state_nxt = ST_RESP;
               end else begin
                  w_i_state_nxt = ST_WAIT;
                  w_i_cnt_nxt   = CW'(LATENCY - 1);
               end
            end
         end
         ST_WAIT: begin
            w_i_cnt_nxt = r_i_cnt - 1'b1;
            if (r_i_cnt == CW'(1)) begin
               w_i_state_nxt = ST_RESP;
            end
         end
         ST_RESP: begin
            w_i_rsp_valid = 1'b1;
            if (i_rsp_ready) begin
               w_i_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_i_state_nxt = ST_IDLE;
            w_i_cnt_nxt   = '0;
         end
      endcase
   end

   // Fetch response register: loaded once at acceptance, held until consumed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_i_rdata <= '0;
         r_i_err   <= 1'b0;
      end else if (w_i_accept) begin
         r_i_err   <= w_i_err;
         r_i_rdata <= w_i_err ? '0 : w_i_rdata;
      end
   end

endmodule

// File: tb/tb_ysyx_22040729_hs_mem.sv
// Bench for ysyx_22040729_hs_mem. Three instances with LATENCY 1, 3 and 4.
// Drivers issue requests and queue the hand-computed response. Monitors pop
// and compare on every response handshake, and they also check latency,
// payload stability and req_ready while a response is pending.
module tb_ysyx_22040729_hs_mem;

   localparam int N  = 3;
   localparam int AW = 16;
   localparam int DW = 64;
   localparam int IW = 32;
   localparam int DB = DW / 8;

   function automatic int lat_of(input int g);
      return (g == 0) ? 1 : ((g == 1) ? 3 : 4);
   endfunction

   typedef struct packed {
      logic [1:0]  dut;
      logic [63:0] data;
      logic        err;
      logic [31:0] acc;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst         [N];
   logic          d_req_valid [N];
   logic          d_req_ready [N];
   logic [AW-1:0] d_req_addr  [N];
   logic          d_req_wen   [N];
   logic [DB-1:0] d_req_wstrb [N];
   logic [DW-1:0] d_req_wdata [N];
   logic          d_rsp_valid [N];
   logic          d_rsp_ready [N];
   logic [DW-1:0] d_rsp_rdata [N];
   logic          d_rsp_err   [N];
   logic          i_req_valid [N];
   logic          i_req_ready [N];
   logic [AW-1:0] i_req_addr  [N];
   logic          i_rsp_valid [N];
   logic          i_rsp_ready [N];
   logic [IW-1:0] i_rsp_rdata [N];
   logic          i_rsp_err   [N];

   for (genvar g = 0; g < N; g++) begin : g_dut
      ysyx_22040729_hs_mem #(
         .DEPTH      (65536),
         .DATA_WIDTH (DW),
         .INST_WIDTH (IW),
         .LATENCY    ((g == 0) ? 1 : ((g == 1) ? 3 : 4))
      ) u_dut (
         .clk         (clk),
         .rst         (rst[g]),
         .d_req_valid (d_req_valid[g]),
         .d_req_ready (d_req_ready[g]),
         .d_req_addr  (d_req_addr[g]),
         .d_req_wen   (d_req_wen[g]),
         .d_req_wstrb (d_req_wstrb[g]),
         .d_req_wdata (d_req_wdata[g]),
         .d_rsp_valid (d_rsp_valid[g]),
         .d_rsp_ready (d_rsp_ready[g]),
         .d_rsp_rdata (d_rsp_rdata[g]),
         .d_rsp_err   (d_rsp_err[g]),
         .i_req_valid (i_req_valid[g]),
         .i_req_ready (i_req_ready[g]),
         .i_req_addr  (i_req_addr[g]),
         .i_rsp_valid (i_rsp_valid[g]),
         .i_rsp_ready (i_rsp_ready[g]),
         .i_rsp_rdata (i_rsp_rdata[g]),
         .i_rsp_err   (i_rsp_err[g])
      );
   end

   // ---------------- clock / cycle count ----------------
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard state ----------------
   int   n_chk = 0;
   int   n_err = 0;
   exp_t d_q[$];
   exp_t i_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      n_chk++;
      n_err++;
      $display("FAIL %s: bound expired at cycle %0d", name, cyc);
   endtask

   // ---------------- driver tasks ----------------
   task automatic d_req(input int p, input logic [AW-1:0] addr, input logic wen,
                        input logic [DB-1:0] strb, input logic [DW-1:0] wdata,
                        input logic [63:0] exp_data, input logic exp_err, input bit push);
      exp_t e;
      bit   ok;
      d_req_valid[p] = 1'b1;
      d_req_addr[p]  = addr;
      d_req_wen[p]   = wen;
      d_req_wstrb[p] = strb;
      d_req_wdata[p] = wdata;
      ok = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (d_req_ready[p]) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         fail_now("d_req_accept");
      end else begin
         @(posedge clk);
         #1;
         e.dut  = 2'(p);
         e.data = exp_data;
         e.err  = exp_err;
         e.acc  = cyc;
         if (push) d_q.push_back(e);
      end
      d_req_valid[p] = 1'b0;
   endtask

   task automatic i_req(input int p, input logic [AW-1:0] addr,
                        input logic [31:0] exp_data, input logic exp_err);
      exp_t e;
      bit   ok;
      i_req_valid[p] = 1'b1;
      i_req_addr[p]  = addr;
      ok = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (i_req_ready[p]) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         fail_now("i_req_accept");
      end else begin
         @(posedge clk);
         #1;
         e.dut  = 2'(p);
         e.data = {32'h0, exp_data};
         e.err  = exp_err;
         e.acc  = cyc;
         i_q.push_back(e);
      end
      i_req_valid[p] = 1'b0;
   endtask

   // Data write and fetch presented together so both are accepted on one edge.
   task automatic both_req(input int p, input logic [AW-1:0] d_addr, input logic [DB-1:0] strb,
                           input logic [DW-1:0] wdata, input logic [AW-1:0] i_addr,
                           input logic [31:0] i_exp);
      exp_t e;
      bit   ok;
      d_req_valid[p] = 1'b1;
      d_req_addr[p]  = d_addr;
      d_req_wen[p]   = 1'b1;
      d_req_wstrb[p] = strb;
      d_req_wdata[p] = wdata;
      i_req_valid[p] = 1'b1;
      i_req_addr[p]  = i_addr;
      ok = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (d_req_ready[p] && i_req_ready[p]) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         fail_now("both_req_accept");
      end else begin
         @(posedge clk);
         #1;
         e.dut = 2'(p);
         e.acc = cyc;
         e.err = 1'b0;
         e.data = 64'h0;
         d_q.push_back(e);
         e.data = {32'h0, i_exp};
         i_q.push_back(e);
      end
      d_req_valid[p] = 1'b0;
      i_req_valid[p] = 1'b0;
   endtask

   task automatic wait_drain();
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (d_q.size() == 0 && i_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         fail_now("drain");
         d_q.delete();
         i_q.delete();
      end
      @(posedge clk);
      #1;
   endtask

   // ---------------- data-port monitor ----------------
   bit          d_seen [N];
   logic [63:0] d_hold [N];
   logic        d_herr [N];

   always @(negedge clk) begin
      for (int p = 0; p < N; p++) begin
         if (rst[p]) begin
            d_seen[p] = 1'b0;
         end else if (d_rsp_valid[p]) begin
            if (!d_seen[p]) begin
               if (d_q.size() == 0) begin
                  fail_now("d_unexpected_rsp");
               end else begin
                  check("d_rsp_dut", 64'(p), 64'(d_q[0].dut));
                  check("d_latency", 64'(cyc - d_q[0].acc), 64'(lat_of(p) - 1));
               end
               d_seen[p] = 1'b1;
               d_hold[p] = d_rsp_rdata[p];
               d_herr[p] = d_rsp_err[p];
            end else begin
               check("d_stable_rdata", d_rsp_rdata[p], d_hold[p]);
               check("d_stable_err", 64'(d_rsp_err[p]), 64'(d_herr[p]));
            end
            check("d_req_ready_in_resp", 64'(d_req_ready[p]), 64'h0);
            if (d_rsp_ready[p]) begin
               if (d_q.size() != 0) begin
                  check("d_rdata", d_rsp_rdata[p], d_q[0].data);
                  check("d_err", 64'(d_rsp_err[p]), 64'(d_q[0].err));
                  void'(d_q.pop_front());
               end
               d_seen[p] = 1'b0;
            end
         end
      end
   end

   // ---------------- fetch-port monitor ----------------
   bit          i_seen [N];
   logic [31:0] i_hold [N];
   logic        i_herr [N];

   always @(negedge clk) begin
      for (int p = 0; p < N; p++) begin
         if (rst[p]) begin
            i_seen[p] = 1'b0;
         end else if (i_rsp_valid[p]) begin
            if (!i_seen[p]) begin
               if (i_q.size() == 0) begin
                  fail_now("i_unexpected_rsp");
               end else begin
                  check("i_rsp_dut", 64'(p), 64'(i_q[0].dut));
                  check("i_latency", 64'(cyc - i_q[0].acc), 64'(lat_of(p) - 1));
               end
               i_seen[p] = 1'b1;
               i_hold[p] = i_rsp_rdata[p];
               i_herr[p] = i_rsp_err[p];
            end else begin
               check("i_stable_rdata", 64'(i_rsp_rdata[p]), 64'(i_hold[p]));
               check("i_stable_err", 64'(i_rsp_err[p]), 64'(i_herr[p]));
            end
            check("i_req_ready_in_resp", 64'(i_req_ready[p]), 64'h0);
            if (i_rsp_ready[p]) begin
               if (i_q.size() != 0) begin
                  check("i_rdata", 64'(i_rsp_rdata[p]), i_q[0].data);
                  check("i_err", 64'(i_rsp_err[p]), 64'(i_q[0].err));
                  void'(i_q.pop_front());
               end
               i_seen[p] = 1'b0;
            end
         end
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      n_err++;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   int v_cnt;

   initial begin
      for (int p = 0; p < N; p++) begin
         rst[p]         = 1'b1;
         d_req_valid[p] = 1'b0;
         d_req_addr[p]  = '0;
         d_req_wen[p]   = 1'b0;
         d_req_wstrb[p] = '0;
         d_req_wdata[p] = '0;
         d_rsp_ready[p] = 1'b1;
         i_req_valid[p] = 1'b0;
         i_req_addr[p]  = '0;
         i_rsp_ready[p] = 1'b1;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      // Reset state of every instance.
      for (int p = 0; p < N; p++) begin
         check("rst_d_req_ready", 64'(d_req_ready[p]), 64'h0);
         check("rst_d_rsp_valid", 64'(d_rsp_valid[p]), 64'h0);
         check("rst_d_rsp_rdata", d_rsp_rdata[p], 64'h0);
         check("rst_d_rsp_err", 64'(d_rsp_err[p]), 64'h0);
         check("rst_i_req_ready", 64'(i_req_ready[p]), 64'h0);
         check("rst_i_rsp_valid", 64'(i_rsp_valid[p]), 64'h0);
         check("rst_i_rsp_rdata", 64'(i_rsp_rdata[p]), 64'h0);
         check("rst_i_rsp_err", 64'(i_rsp_err[p]), 64'h0);
      end
      for (int p = 0; p < N; p++) rst[p] = 1'b0;
      @(posedge clk);
      #1;

      // ---- LATENCY=1: full write, read back ----
      d_req(0, 16'h0010, 1'b1, 8'hFF, 64'h1122334455667788, 64'h0, 1'b0, 1'b1);
      d_req(0, 16'h0010, 1'b0, 8'h00, 64'h0, 64'h1122334455667788, 1'b0, 1'b1);
      wait_drain();
      // ---- strobe merge ----
      d_req(0, 16'h0010, 1'b1, 8'h0F, 64'hAAAAAAAAAAAAAAAA, 64'h0, 1'b0, 1'b1);
      d_req(0, 16'h0010, 1'b0, 8'h00, 64'h0, 64'h11223344AAAAAAAA, 1'b0, 1'b1);
      i_req(0, 16'h0012, 32'h3344AAAA, 1'b0);
      wait_drain();
      // ---- wstrb=0 is a no-op write ----
      d_req(0, 16'h0010, 1'b1, 8'h00, 64'h5555555555555555, 64'h0, 1'b0, 1'b1);
      d_req(0, 16'h0010, 1'b0, 8'h00, 64'h0, 64'h11223344AAAAAAAA, 1'b0, 1'b1);
      wait_drain();

      // ---- range checks at the top of memory ----
      d_req(0, 16'hFFF8, 1'b1, 8'hFF, 64'h0123456789ABCDEF, 64'h0, 1'b0, 1'b1);
      d_req(0, 16'hFFFC, 1'b0, 8'h00, 64'h0, 64'h0, 1'b1, 1'b1);
      d_req(0, 16'hFFF9, 1'b1, 8'hFF, 64'hFFFFFFFFFFFFFFFF, 64'h0, 1'b1, 1'b1);
      d_req(0, 16'hFFF9, 1'b0, 8'h00, 64'h0, 64'h0, 1'b1, 1'b1);
      d_req(0, 16'hFFF8, 1'b0, 8'h00, 64'h0, 64'h0123456789ABCDEF, 1'b0, 1'b1);
      i_req(0, 16'hFFFC, 32'h01234567, 1'b0);
      i_req(0, 16'hFFFD, 32'h0, 1'b1);
      wait_drain();

      // ---- same-edge write/fetch collision ----
      d_req(0, 16'h0020, 1'b1, 8'h0F, 64'h00000000DEADBEEF, 64'h0, 1'b0, 1'b1);
      wait_drain();
      both_req(0, 16'h0020, 8'hFF, 64'h0, 16'h0020, 32'hDEADBEEF);
      wait_drain();
      i_req(0, 16'h0020, 32'h00000000, 1'b0);
      wait_drain();

      // ---- LATENCY=3 with back-pressure on the response ----
      d_req(1, 16'h0030, 1'b1, 8'hFF, 64'h0102030405060708, 64'h0, 1'b0, 1'b1);
      wait_drain();
      d_rsp_ready[1] = 1'b0;
      d_req(1, 16'h0030, 1'b0, 8'h00, 64'h0, 64'h0102030405060708, 1'b0, 1'b1);
      v_cnt = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (d_rsp_valid[1]) break;
         v_cnt++;
      end
      check("lat3_valid_seen", 64'(d_rsp_valid[1]), 64'h1);
      repeat (5) @(posedge clk);
      #1;
      d_rsp_ready[1] = 1'b1;
      wait_drain();
      i_req(1, 16'h0034, 32'h01020304, 1'b0);
      wait_drain();

      // ---- LATENCY=4: reset while a read is waiting ----
      d_req(2, 16'h0040, 1'b1, 8'hFF, 64'hCAFEF00D12345678, 64'h0, 1'b0, 1'b1);
      wait_drain();
      d_req(2, 16'h0040, 1'b0, 8'h00, 64'h0, 64'h0, 1'b0, 1'b0);
      @(posedge clk);
      #3;
      rst[2] = 1'b1;
      #1;
      check("midrst_d_rsp_valid", 64'(d_rsp_valid[2]), 64'h0);
      check("midrst_d_req_ready", 64'(d_req_ready[2]), 64'h0);
      check("midrst_d_rsp_rdata", d_rsp_rdata[2], 64'h0);
      check("midrst_d_rsp_err", 64'(d_rsp_err[2]), 64'h0);
      check("midrst_i_req_ready", 64'(i_req_ready[2]), 64'h0);
      repeat (2) @(negedge clk);
      rst[2] = 1'b0;
      v_cnt = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (d_rsp_valid[2]) v_cnt++;
      end
      check("postrst_no_rsp", 64'(v_cnt), 64'h0);
      @(posedge clk);
      #1;
      d_req(2, 16'h0040, 1'b0, 8'h00, 64'h0, 64'hCAFEF00D12345678, 1'b0, 1'b1);
      wait_drain();

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
